// File: rtl/scan_display_pkg.sv
// Shared types, glyph constants and elaboration-time helpers for the
// multiplexed seven-segment driver.
//   bcd_digit_t      : one BCD decade
//   GLYPH_*          : active-high segment patterns, bit order g..a
//   pow10()          : 10^n as a 64-bit constant (overflow limits)
//   bcd_nibbles()    : ceil(width*log10(2)), decades for a width-bit magnitude
//   digit_glyph()    : decade -> segment pattern
package scan_display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Smallest k with 10^k >= 2^width, which equals ceil(width*log10 2)
  // because a power of two is never a power of ten (width > 0).
  function automatic int unsigned bcd_nibbles(input int unsigned width);
    int unsigned n;
    n = 19;
    for (int k = 19; k >= 1; k--)
      if (pow10(k) >= (64'd1 << width)) n = k;
    return n;
  endfunction

  function automatic logic [6:0] digit_glyph(input bcd_digit_t d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/scan_display_driver_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   state  | meaning
//   IDLE   | waiting for start; result of last conversion held on bcd
//   SHIFT  | one add-3/shift step per cycle, VALUE_WIDTH cycles
//   COMMIT | done=1 for one cycle, bcd is final
// Ports: clk, reset (async active-low), start, value -> busy, done, bcd.
module bin2bcd_seq
  import scan_display_pkg::*;
#(
  parameter int VALUE_WIDTH = 14,
  parameter int NIBBLES     = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   bcd
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam int CW = $clog2(VALUE_WIDTH + 1);

  state_t                 state;
  logic [VALUE_WIDTH-1:0] sr;
  logic [CW-1:0]          cnt;
  logic [4*NIBBLES-1:0]   adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NIBBLES; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= value;
            bcd   <= '0;
            cnt   <= CW'(VALUE_WIDTH - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sr} <= {adj, sr} << 1;
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= COMMIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COMMIT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scan_display_driver.sv
// Multiplexed seven-segment driver with sequential BCD conversion,
// leading-zero blanking, minus sign, live decimal points and overflow.
// Ports:
//   clk, reset (async active-low)
//   value/negative/blank_lz : captured on load while not busy
//   load                    : one-cycle conversion strobe
//   dp_mask                 : decimal points, used live
//   com                     : digit enables, bit 0 = leftmost
//   seg                     : {dp, g..a}
//   busy, overflow
module scan_display_driver
  import scan_display_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SCAN_FREQ      = 250,
  parameter int DIGITS         = 4,
  parameter int VALUE_WIDTH    = 14,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   negative,
  input  logic                   load,
  input  logic                   blank_lz,
  input  logic [DIGITS-1:0]      dp_mask,
  output logic [DIGITS-1:0]      com,
  output logic [7:0]             seg,
  output logic                   busy,
  output logic                   overflow
);

  localparam int TICK         = CLK_FREQ / (SCAN_FREQ * DIGITS);
  localparam int TW           = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int SW           = $clog2(DIGITS);
  localparam int NIBBLES_FULL = bcd_nibbles(VALUE_WIDTH);
  // Double-dabble carries only move upward, so decades above the shown
  // ones can be dropped without disturbing the lower ones; values that
  // would need them are caught by the overflow compare.
  localparam int CONV_NIBBLES = (NIBBLES_FULL < DIGITS) ? NIBBLES_FULL : DIGITS;
  localparam logic [63:0] LIMIT_POS = pow10(DIGITS);
  localparam logic [63:0] LIMIT_NEG = pow10(DIGITS - 1);
  localparam logic [DIGITS-1:0] COM_INV = (COM_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  if (TICK < 1) begin : g_bad_tick
    $error("scan_display_driver: CLK_FREQ/(SCAN_FREQ*DIGITS) must be >= 1");
  end
  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("scan_display_driver: DIGITS must be in 2..8");
  end

  logic [VALUE_WIDTH-1:0]  val_l;
  logic                    neg_l;
  logic                    blz_l;
  logic                    done;
  logic [4*CONV_NIBBLES-1:0] bcd;
  logic [4*DIGITS-1:0]     bcd_pad;
  logic                    ovf_next;

  bcd_digit_t              disp_dig [DIGITS];
  logic                    disp_sign;
  logic                    disp_blz;
  logic                    disp_ovf;

  logic [TW-1:0]           tick;
  logic [SW-1:0]           scan_idx;
  logic [SW-1:0]           msd;
  logic [6:0]              glyph;
  logic                    dp_bit;

  bin2bcd_seq #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .NIBBLES     (CONV_NIBBLES)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (load),
    .value (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  assign bcd_pad  = (4*DIGITS)'(bcd);
  assign ovf_next = (neg_l && val_l != '0) ? (64'(val_l) >= LIMIT_NEG)
                                           : (64'(val_l) >= LIMIT_POS);
  assign overflow = disp_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_l     <= '0;
      neg_l     <= 1'b0;
      blz_l     <= 1'b1;
      disp_sign <= 1'b0;
      disp_blz  <= 1'b1;
      disp_ovf  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp_dig[i] <= '0;
    end else begin
      if (load && !busy) begin
        val_l <= value;
        neg_l <= negative;
        blz_l <= blank_lz;
      end
      if (done) begin
        disp_sign <= neg_l && (val_l != '0);
        disp_blz  <= blz_l;
        disp_ovf  <= ovf_next;
        // Position 0 is leftmost, so it holds the highest shown decade.
        for (int i = 0; i < DIGITS; i++)
          disp_dig[i] <= bcd_pad[4*(DIGITS-1-i) +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick     <= '0;
      scan_idx <= '0;
    end else if (tick == TW'(TICK - 1)) begin
      tick     <= '0;
      scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Leftmost nonzero position; the rightmost digit when the value is zero.
  always_comb begin
    msd = SW'(DIGITS - 1);
    for (int i = DIGITS - 1; i >= 0; i--)
      if (disp_dig[i] != 4'd0) msd = SW'(i);
  end

  always_comb begin
    glyph  = digit_glyph(disp_dig[scan_idx]);
    dp_bit = dp_mask[scan_idx] && !disp_ovf;
    if (disp_ovf) begin
      glyph = GLYPH_MINUS;
    end else if (scan_idx != SW'(DIGITS - 1)) begin
      if (disp_blz) begin
        if (disp_sign && msd != '0 && scan_idx == msd - 1'b1) glyph = GLYPH_MINUS;
        else if (scan_idx < msd)                               glyph = GLYPH_BLANK;
      end else if (disp_sign && scan_idx == '0) begin
        // No overflow with a sign guarantees the leftmost decade is zero.
        glyph = GLYPH_MINUS;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      com <= COM_INV;
      seg <= SEG_INV;
    end else begin
      com <= (DIGITS'(1) << scan_idx) ^ COM_INV;
      seg <= {dp_bit, glyph} ^ SEG_INV;
    end
  end

endmodule

// File: tb/tb_scan_display_driver.sv
module tb_scan_display_driver;

  localparam int DIGITS = 4;
  localparam int VW     = 14;
  localparam int TICK   = 4;

  logic            clk;
  logic            reset;
  logic [VW-1:0]   value;
  logic            negative;
  logic            load;
  logic            blank_lz;
  logic [DIGITS-1:0] dp_mask;
  logic [DIGITS-1:0] com;
  logic [7:0]      seg;
  logic            busy;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_seg  [DIGITS];
  bit         cap_seen [DIGITS];
  int         cap_bad;

  scan_display_driver #(
    .CLK_FREQ       (800),
    .SCAN_FREQ      (50),
    .DIGITS         (DIGITS),
    .VALUE_WIDTH    (VW),
    .COM_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .negative (negative),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .com      (com),
    .seg      (seg),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_digit(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic int ipow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic bit ref_ovf(input int v, input bit neg);
    if (neg && v != 0) return v >= ipow10(DIGITS - 1);
    return v >= ipow10(DIGITS);
  endfunction

  // Glyph at position i (0 = leftmost), from the printed decimal text.
  function automatic logic [6:0] ref_pos(input int v, input bit neg, input bit blz, input int i);
    int  dec;
    int  nd;
    int  digit;
    bit  sign;
    dec  = DIGITS - 1 - i;
    sign = neg && (v != 0);
    if (ref_ovf(v, neg)) return 7'b1000000;
    nd = 1;
    for (int t = v; t >= 10; t = t / 10) nd++;
    digit = (v / ipow10(dec)) % 10;
    if (blz) begin
      if (dec < nd)            return ref_digit(digit);
      if (sign && dec == nd)   return 7'b1000000;
      return 7'b0000000;
    end
    if (sign && i == 0) return 7'b1000000;
    return ref_digit(digit);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input int v, input bit neg, input bit blz, output int n);
    @(negedge clk);
    value = VW'(v); negative = neg; blank_lz = blz; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic capture_frame();
    int act;
    int idx;
    cap_bad = 0;
    for (int i = 0; i < DIGITS; i++) cap_seen[i] = 1'b0;
    for (int k = 0; k < DIGITS * TICK; k++) begin
      @(posedge clk); #1;
      act = 0; idx = 0;
      for (int j = 0; j < DIGITS; j++) if (com[j] === 1'b0) begin act++; idx = j; end
      if (act != 1) cap_bad++;
      else begin
        if (cap_seen[idx] && cap_seg[idx] !== seg) cap_bad++;
        cap_seg[idx]  = seg;
        cap_seen[idx] = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #23;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int idx;
    logic [DIGITS-1:0] exp_com;
    reset = 1'b0; load = 1'b0; value = '0; negative = 1'b0; blank_lz = 1'b0; dp_mask = '0;
    #23;
    checks++; if (com !== 4'b1111) begin errors++; $display("FAIL reset_com: got %b expected 1111", com); end
    checks++; if (seg !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h expected 00", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 2 * DIGITS * TICK; k++) begin
      @(posedge clk); #1;
      idx = ((k - 1) / TICK) % DIGITS;
      exp_com = ~(DIGITS'(1) << idx);
      checks++;
      if (com !== exp_com) begin errors++; $display("FAIL scan_com k=%0d: got %b expected %b", k, com, exp_com); end
      checks++;
      if (seg !== {1'b0, ref_pos(0, 1'b0, 1'b1, idx)})
        begin errors++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, {1'b0, ref_pos(0, 1'b0, 1'b1, idx)}); end
    end
  endtask

  task automatic test_convert();
    int n;
    int act;
    int idx;
    dp_mask = '0;
    do_load(5678, 1'b0, 1'b1, n);
    checks++; if (n !== 15) begin errors++; $display("FAIL conv_busy_5678: got %0d expected 15", n); end
    // Second load: the old digits must stay on the pins while busy.
    @(negedge clk);
    value = VW'(1234); negative = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      act = 0; idx = 0;
      for (int j = 0; j < DIGITS; j++) if (com[j] === 1'b0) begin act++; idx = j; end
      checks++;
      if (act != 1 || seg[6:0] !== ref_pos(5678, 1'b0, 1'b1, idx))
        begin errors++; $display("FAIL conv_old_shown cyc=%0d: got com=%b seg=%h expected old digit %0d", n, com, seg, idx); end
      @(posedge clk); #1;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL conv_busy_1234: got %0d expected 15", n); end
    capture_frame();
    checks++; if (cap_bad != 0) begin errors++; $display("FAIL conv_frame_com: got %0d bad samples expected 0", cap_bad); end
    for (int i = 0; i < DIGITS; i++) begin
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== {1'b0, ref_pos(1234, 1'b0, 1'b1, i)})
        begin errors++; $display("FAIL conv_1234_d%0d: got %h expected %h", i, cap_seg[i], {1'b0, ref_pos(1234, 1'b0, 1'b1, i)}); end
    end
  endtask

  task automatic test_sign_overflow();
    int tv [9]  = '{7, 7, 0, 10000, 9999, 999, 1000, 0, 99};
    bit tn [9]  = '{1, 1, 1, 0,     0,    1,   1,    0, 1};
    bit tb [9]  = '{1, 0, 0, 1,     1,    1,   0,    0, 0};
    int n;
    dp_mask = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      do_load(tv[c], tn[c], tb[c], n);
      checks++; if (n !== 15) begin errors++; $display("FAIL sign_busy v=%0d: got %0d expected 15", tv[c], n); end
      checks++;
      if (overflow !== ref_ovf(tv[c], tn[c]))
        begin errors++; $display("FAIL sign_ovf v=%0d neg=%0d: got %b expected %b", tv[c], tn[c], overflow, ref_ovf(tv[c], tn[c])); end
      capture_frame();
      checks++; if (cap_bad != 0) begin errors++; $display("FAIL sign_frame_com v=%0d: got %0d bad samples expected 0", tv[c], cap_bad); end
      for (int i = 0; i < DIGITS; i++) begin
        checks++;
        if (!cap_seen[i] || cap_seg[i] !== {!ref_ovf(tv[c], tn[c]), ref_pos(tv[c], tn[c], tb[c], i)})
          begin errors++; $display("FAIL sign_v%0d_n%0d_b%0d_d%0d: got %h expected %h", tv[c], tn[c], tb[c], i,
                                   cap_seg[i], {!ref_ovf(tv[c], tn[c]), ref_pos(tv[c], tn[c], tb[c], i)}); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    dp_mask = 4'b0100;
    @(negedge clk);
    value = VW'(42); negative = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin value = VW'(99); negative = 1'b1; blank_lz = 1'b0; load = 1'b1; end
      @(posedge clk); #1;
      load = 1'b0;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL b2b_busy: got %0d expected 15", n); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
    capture_frame();
    checks++; if (cap_bad != 0) begin errors++; $display("FAIL b2b_frame_com: got %0d bad samples expected 0", cap_bad); end
    for (int i = 0; i < DIGITS; i++) begin
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== {(i == 2), ref_pos(42, 1'b0, 1'b1, i)})
        begin errors++; $display("FAIL b2b_d%0d: got %h expected %h", i, cap_seg[i], {(i == 2), ref_pos(42, 1'b0, 1'b1, i)}); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    dp_mask = '0;
    @(negedge clk);
    value = VW'(4321); negative = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n = 1;
    while (n < 5) begin n++; @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
    checks++; if (com !== 4'b1111) begin errors++; $display("FAIL mid_com: got %b expected 1111", com); end
    @(negedge clk);
    reset = 1'b1;
    capture_frame();
    for (int i = 0; i < DIGITS; i++) begin
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== {1'b0, ref_pos(0, 1'b0, 1'b1, i)})
        begin errors++; $display("FAIL mid_zero_d%0d: got %h expected %h", i, cap_seg[i], {1'b0, ref_pos(0, 1'b0, 1'b1, i)}); end
    end
    do_load(5, 1'b0, 1'b1, n);
    checks++; if (n !== 15) begin errors++; $display("FAIL mid_busy_5: got %0d expected 15", n); end
    capture_frame();
    for (int i = 0; i < DIGITS; i++) begin
      checks++;
      if (!cap_seen[i] || cap_seg[i] !== {1'b0, ref_pos(5, 1'b0, 1'b1, i)})
        begin errors++; $display("FAIL mid_five_d%0d: got %h expected %h", i, cap_seg[i], {1'b0, ref_pos(5, 1'b0, 1'b1, i)}); end
    end
  endtask

  task automatic test_random();
    int v;
    bit neg;
    bit blz;
    int n;
    logic [7:0] exp;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, (1 << VW) - 1);
      endcase
      neg = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      dp_mask = DIGITS'($urandom);
      do_load(v, neg, blz, n);
      checks++; if (n !== 15) begin errors++; $display("FAIL rnd_busy v=%0d: got %0d expected 15", v, n); end
      checks++;
      if (overflow !== ref_ovf(v, neg))
        begin errors++; $display("FAIL rnd_ovf v=%0d neg=%0d: got %b expected %b", v, neg, overflow, ref_ovf(v, neg)); end
      capture_frame();
      checks++; if (cap_bad != 0) begin errors++; $display("FAIL rnd_frame_com v=%0d: got %0d bad samples expected 0", v, cap_bad); end
      for (int i = 0; i < DIGITS; i++) begin
        exp = {dp_mask[i] && !ref_ovf(v, neg), ref_pos(v, neg, blz, i)};
        checks++;
        if (!cap_seen[i] || cap_seg[i] !== exp)
          begin errors++; $display("FAIL rnd_v%0d_n%0d_b%0d_d%0d: got %h expected %h", v, neg, blz, i, cap_seg[i], exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_sign_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
